// File: rtl/seg7_display_scan.sv
// seg7_display_scan: signed binary to sign+5-digit BCD with multiplexed 7-segment scan
module seg7_display_scan #(
    parameter int DATA_W = 16,
    parameter int NDIG   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slow_clk,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg
);
    localparam int BCD_W = 4 * (NDIG - 1);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(NDIG);
    localparam logic [3:0] C_DASH  = 4'hA;
    localparam logic [3:0] C_BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             r_state, w_next;
    logic               r_neg;
    logic [DATA_W-1:0]  r_mag, w_mag;
    logic [BCD_W-1:0]   r_bcd, w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_buf [NDIG];
    logic [3:0]         w_code [NDIG];
    logic               w_lead;
    logic [1:0]         r_sync;
    logic               r_prev, w_tick;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         w_seg;

    function automatic logic [6:0] encode(input logic [3:0] c);
        case (c)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            C_DASH:  encode = 7'b0111111;
            default: encode = 7'b1111111;
        endcase
    endfunction

    // conversion state register; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state: load only honoured in IDLE, 16 shifts, one commit cycle
    always_comb begin
        w_next = (r_state == IDLE && load) ? SHIFT :
                 (r_state == SHIFT && r_cnt == CNT_W'(DATA_W - 1)) ? COMMIT :
                 (r_state == COMMIT) ? IDLE : r_state;
        busy   = r_state != IDLE;
    end

    // magnitude (-32768 wraps to 32768 unsigned), add-3 adjust, and blanked digit codes
    always_comb begin
        w_mag  = value[DATA_W-1] ? -value : value;
        w_adj  = r_bcd;
        w_lead = 1'b1;
        for (int i = 0; i < NDIG - 1; i++)
            w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
        for (int i = 0; i < NDIG; i++)
            w_code[i] = C_BLANK;
        for (int i = NDIG - 2; i >= 1; i--) begin
            w_lead    = w_lead && (r_bcd[4*i +: 4] == 4'd0);
            w_code[i] = w_lead ? C_BLANK : r_bcd[4*i +: 4];
        end
        w_code[0]      = r_bcd[3:0];
        w_code[NDIG-1] = r_neg ? C_DASH : C_BLANK;
    end

    // double-dabble datapath and display buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg <= 1'b0;
            r_mag <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            for (int i = 0; i < NDIG; i++) r_buf[i] <= C_BLANK;
        end else if (r_state == IDLE && load) begin
            r_neg <= value[DATA_W-1];
            r_mag <= w_mag;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            {r_bcd, r_mag} <= {w_adj, r_mag} << 1;
            r_cnt          <= r_cnt + 1'b1;
        end else if (r_state == COMMIT) begin
            for (int i = 0; i < NDIG; i++) r_buf[i] <= w_code[i];
        end
    end

    // slow_clk synchronizer, rising-edge detect and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_sync <= {r_sync[0], slow_clk};
            r_prev <= r_sync[1];
            if (w_tick) r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    assign w_tick = r_sync[1] & ~r_prev;
    assign w_seg  = encode(r_buf[r_idx]);

    // registered digit enable and segment outputs, updated together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= ~NDIG'(1);
            seg <= 7'b1111111;
        end else begin
            an  <= ~(NDIG'(1) << r_idx);
            seg <= w_seg;
        end
    end
endmodule

// File: tb/tb_seg7_display_scan.sv
// tb_seg7_display_scan: randomized and directed checks against a decimal display model
module tb_seg7_display_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slow_clk = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        busy;
    logic [5:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int failures = 0;
    int idx = 0;
    int shown = 0;
    bit shown_valid = 1'b0;
    logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg7_display_scan #(.DATA_W(16), .NDIG(6)) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .load(load),
        .value(value), .busy(busy), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    // expected pattern for digit d of the value currently shown
    function automatic logic [6:0] exp_seg(input int d);
        int mag = (shown < 0) ? -shown : shown;
        int p = 1;
        if (!shown_valid) return 7'b1111111;
        if (d == 5) return (shown < 0) ? 7'b0111111 : 7'b1111111;
        for (int i = 0; i < d; i++) p = p * 10;
        if (d > 0 && mag < p) return 7'b1111111;
        return enc[(mag / p) % 10];
    endfunction

    function automatic logic [5:0] exp_an(input int i);
        logic [5:0] one = 6'b000001;
        return ~(one << i);
    endfunction

    task automatic step_scan(input string name);
        @(negedge clk) slow_clk = 1'b1;
        repeat (6) @(negedge clk);
        slow_clk = 1'b0;
        repeat (6) @(negedge clk);
        idx = (idx + 1) % 6;
        checks++;
        if (an !== exp_an(idx)) begin
            failures++;
            $display("FAIL %s an idx=%0d got=%b exp=%b", name, idx, an, exp_an(idx));
        end
        checks++;
        if (seg !== exp_seg(idx)) begin
            failures++;
            $display("FAIL %s seg idx=%0d got=%b exp=%b", name, idx, seg, exp_seg(idx));
        end
    endtask

    task automatic pulse_load(input int v);
        @(negedge clk);
        load = 1'b1;
        value = 16'(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_load(input int v, input string name);
        int n;
        pulse_load(v);
        wait_idle(n);
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=17", name, n);
        end
        shown = v;
        shown_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (seg !== exp_seg(idx)) begin
            failures++;
            $display("FAIL %s seg_e18 idx=%0d got=%b exp=%b", name, idx, seg, exp_seg(idx));
        end
        repeat (6) step_scan(name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || an !== 6'b111110 || seg !== 7'b1111111) begin
            failures++;
            $display("FAIL reset busy/an/seg got=%b/%b/%b exp=0/111110/1111111", busy, an, seg);
        end
        rst = 1'b0;
        idx = 0;
    endtask

    task automatic test_scan_idle;
        repeat (6) step_scan("scan_idle");
    endtask

    task automatic test_directed;
        run_load(12345, "v12345");
        run_load(-16256, "vneg16256");
        run_load(0, "vzero");
        run_load(-32768, "vmin");
        run_load(7, "v7");
    endtask

    task automatic test_random;
        repeat (5) run_load(int'($urandom_range(0, 65535)) - 32768, "random");
    endtask

    task automatic test_back_to_back;
        int n;
        pulse_load(100);
        repeat (4) @(negedge clk);
        load = 1'b1;
        value = 16'd999;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        shown = 100;
        shown_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b busy_after got=%b exp=0", busy);
        end
        repeat (6) step_scan("b2b");
    endtask

    task automatic test_reset_mid;
        pulse_load(-12345);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || an !== 6'b111110 || seg !== 7'b1111111) begin
            failures++;
            $display("FAIL reset_mid busy/an/seg got=%b/%b/%b exp=0/111110/1111111", busy, an, seg);
        end
        @(negedge clk) rst = 1'b0;
        idx = 0;
        shown_valid = 1'b0;
        repeat (6) step_scan("reset_blank");
        run_load(42, "v42");
    endtask

    initial begin
        test_reset;
        test_scan_idle;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
